node_emitter: RTL and testbench

- Inverse of the input parser: takes 15-bit node tokens and newline markers and serialises them back to an ASCII character stream in puzzle-input format, e.g. "you: bbb ccc\n".
- Sits at the output/debug end of the part-B pipeline, for dumping the graph or re-feeding it to the parser in loopback tests.
- Uses the same stall-based handshake as the parser on both sides.

---
 rtl/node_emitter_if.sv | 29 ++
 rtl/node_emitter.sv | 133 +++++++++++++
 tb/tb_node_emitter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_emitter_if.sv
`default_nettype none
// ============================================================================
// Module   : node_emitter_if
// Brief    : Token-in / character-out handshake bundle for node_emitter.
//            master = token producer and character consumer (upstream and
//            downstream environment), slave = the emitter itself.
// Revision : 1.0  initial release
// ============================================================================
interface node_emitter_if;
  logic        i_node_vld;
  logic [14:0] i_node_str;
  logic        i_newline;
  logic        o_stall;
  logic        o_vld;
  logic [7:0]  o_char;
  logic        i_stall;
  logic        o_err;

  modport master (
    output i_node_vld, i_node_str, i_newline, i_stall,
    input  o_stall, o_vld, o_char, o_err
  );

  modport slave (
    input  i_node_vld, i_node_str, i_newline, i_stall,
    output o_stall, o_vld, o_char, o_err
  );
endinterface
`default_nettype wire

// File: rtl/node_emitter.sv
`default_nettype none
// ============================================================================
// Module   : node_emitter
// Brief    : Serialises 15-bit node tokens and newline markers back into the
//            ASCII puzzle-input format ("you: bbb ccc\n"), one char per cycle.
// Revision : 1.0  initial release
// ============================================================================
module node_emitter #(
  parameter logic [7:0] SEP_FIRST = 8'd58,  // ':' after the first node of a line
  parameter logic [7:0] SEP       = 8'd32,  // ' ' before every later node
  parameter logic [7:0] BAD_CHAR  = 8'd63   // '?' for letter codes 26..31
) (
  input  wire logic     clk,
  input  wire logic     rst,
  node_emitter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] C_NEWLINE = 8'h0A;

  state_t      state_q;
  logic [1:0]  idx_q;         // index of the char currently on o_char
  logic        line_start_q;  // next node token opens a new line
  logic [14:0] str_q;
  logic        nl_q;
  logic        vld_q;
  logic [7:0]  char_q;
  logic        err_q;

  logic        busy;
  logic        char_acc;
  logic        last_char;
  logic        tok_done;
  logic        tok_acc;
  logic        line_start_d;
  logic [8:0]  load_d;        // {bad_code, ascii} of the char loaded next

  // {bad, ascii} for one 5-bit letter code
  function automatic logic [8:0] map_letter(input logic [4:0] v);
    if (v < 5'd26) return {1'b0, 8'd97 + {3'b000, v}};
    return {1'b1, BAD_CHAR};
  endfunction

  // {bad, ascii} for char k of a token, given whether it opens a line
  function automatic logic [8:0] char_at(input logic [14:0] s, input logic nl,
                                         input logic ls, input logic [1:0] k);
    logic [1:0] slot;
    logic [8:0] res;
    slot = 2'd0;
    res  = {1'b0, C_NEWLINE};
    if (!nl) begin
      if (ls && (k == 2'd3)) begin
        res = {1'b0, SEP_FIRST};
      end else if (!ls && (k == 2'd0)) begin
        res = {1'b0, SEP};
      end else begin
        // At line start letters occupy slots 0..2, otherwise 1..3
        slot = ls ? k : (k - 2'd1);
        case (slot)
          2'd0:    res = map_letter(s[14:10]);
          2'd1:    res = map_letter(s[9:5]);
          default: res = map_letter(s[4:0]);
        endcase
      end
    end
    return res;
  endfunction

  assign busy      = (state_q == S_BUSY);
  assign char_acc  = vld_q & ~bus.i_stall;
  assign last_char = nl_q | (idx_q == 2'd3);
  assign tok_done  = char_acc & last_char;
  // Freeing the slot in the cycle the last char leaves gives back-to-back tokens
  assign bus.o_stall = busy & ~tok_done;
  assign tok_acc     = bus.i_node_vld & ~bus.o_stall;
  // A token accepted as its predecessor completes must see the updated line state
  assign line_start_d = tok_done ? nl_q : line_start_q;

  assign bus.o_vld  = vld_q;
  assign bus.o_char = char_q;
  assign bus.o_err  = err_q;

  // Select the character to load: first char of a new token, or the next char
  always_comb begin
    load_d = 9'd0;
    if (tok_acc) begin
      load_d = char_at(bus.i_node_str, bus.i_newline, line_start_d, 2'd0);
    end else begin
      load_d = char_at(str_q, nl_q, line_start_q, idx_q + 2'd1);
    end
  end

  // Token sequencing, registered character output and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      line_start_q <= 1'b1;
      str_q        <= 15'd0;
      nl_q         <= 1'b0;
      vld_q        <= 1'b0;
      char_q       <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      line_start_q <= line_start_d;
      if (tok_acc) begin
        state_q <= S_BUSY;
        str_q   <= bus.i_node_str;
        nl_q    <= bus.i_newline;
        idx_q   <= 2'd0;
        vld_q   <= 1'b1;
        char_q  <= load_d[7:0];
        err_q   <= err_q | load_d[8];
      end else if (char_acc) begin
        if (last_char) begin
          state_q <= S_IDLE;
          vld_q   <= 1'b0;
          idx_q   <= 2'd0;
        end else begin
          idx_q   <= idx_q + 2'd1;
          char_q  <= load_d[7:0];
          err_q   <= err_q | load_d[8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_node_emitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_node_emitter
// Brief    : Self-checking bench for node_emitter with a text-level reference
//            model (expected character queue built from the output format).
// Revision : 1.0  initial release
// ============================================================================
module tb_node_emitter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  node_emitter_if bus();

  node_emitter #(
    .SEP_FIRST(8'd58),
    .SEP      (8'd32),
    .BAD_CHAR (8'd63)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    bit         bad;
    bit         last;
  } ent_t;

  ent_t        mq[$];   // chars still owed by the DUT, in order
  logic [7:0]  lq[$];   // chars actually consumed downstream
  int          lc[$];   // cycle numbers of those consumptions
  int          cyc_n = 0;
  bit          ls_m  = 1'b1;
  bit          err_m = 1'b0;
  bit          tacc_last = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Append the text one token must produce to the expected stream
  task automatic push_tok(input logic [14:0] s, input logic nl);
    ent_t       e;
    logic [4:0] l [3];
    if (nl) begin
      e.ch = 8'h0A; e.bad = 1'b0; e.last = 1'b1;
      mq.push_back(e);
      ls_m = 1'b1;
    end else begin
      l[0] = s[14:10]; l[1] = s[9:5]; l[2] = s[4:0];
      if (!ls_m) begin
        e.ch = 8'h20; e.bad = 1'b0; e.last = 1'b0;
        mq.push_back(e);
      end
      for (int i = 0; i < 3; i++) begin
        e.bad  = (l[i] >= 5'd26);
        e.ch   = e.bad ? 8'h3F : (8'h61 + {3'b000, l[i]});
        e.last = !ls_m && (i == 2);
        mq.push_back(e);
      end
      if (ls_m) begin
        e.ch = 8'h3A; e.bad = 1'b0; e.last = 1'b1;
        mq.push_back(e);
      end
      ls_m = 1'b0;
    end
  endtask

  // One clock: compare outputs to the model, account accepts, advance
  task automatic cyc();
    bit ev, es;
    #1;
    ev = (mq.size() != 0);
    if (ev && mq[0].bad) err_m = 1'b1;
    es = ev && !(!bus.i_stall && mq[0].last);
    chk("o_vld", {15'd0, bus.o_vld}, {15'd0, ev});
    chk("o_stall", {15'd0, bus.o_stall}, {15'd0, es});
    if (ev) chk("o_char", {8'd0, bus.o_char}, {8'd0, mq[0].ch});
    chk("o_err", {15'd0, bus.o_err}, {15'd0, err_m});
    tacc_last = bus.i_node_vld && !es;
    if (ev && !bus.i_stall) begin
      lq.push_back(mq[0].ch);
      lc.push_back(cyc_n);
      void'(mq.pop_front());
    end
    if (tacc_last) push_tok(bus.i_node_str, bus.i_newline);
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_node_vld = 1'b0;
    bus.i_stall    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); lq.delete(); lc.delete();
    ls_m = 1'b1; err_m = 1'b0;
    cyc_n++;
    chk("rst_o_vld", {15'd0, bus.o_vld}, 16'd0);
    chk("rst_o_char", {8'd0, bus.o_char}, 16'd0);
    chk("rst_o_err", {15'd0, bus.o_err}, 16'd0);
    chk("rst_o_stall", {15'd0, bus.o_stall}, 16'd0);
  endtask

  task automatic send(input logic [14:0] s, input logic nl, input logic st);
    bus.i_node_vld = 1'b1;
    bus.i_node_str = s;
    bus.i_newline  = nl;
    bus.i_stall    = st;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (tacc_last) break;
    end
    n_cmp++;
    assert (tacc_last) else begin
      n_err++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
    bus.i_node_vld = 1'b0;
  endtask

  task automatic drain();
    bus.i_node_vld = 1'b0;
    bus.i_stall    = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mq.size() == 0) break;
      cyc();
    end
    chk("drain_left", mq.size(), 16'd0);
    cyc();  // one idle cycle: DUT must be quiet again
  endtask

  task automatic chk_log(input string s);
    chk("log_len", lq.size(), s.len());
    for (int i = 0; i < s.len(); i++) begin
      if (i < lq.size()) chk("log_char", {8'd0, lq[i]}, {8'd0, s[i]});
    end
  endtask

  initial begin
    logic [15:0] toks[$];
    logic [15:0] want[4];
    logic [14:0] acc;
    int          nlet;
    logic [4:0]  lv;

    bus.i_node_vld = 1'b0;
    bus.i_node_str = 15'd0;
    bus.i_newline  = 1'b0;
    bus.i_stall    = 1'b0;

    // Reset state
    do_reset();

    // Line format, latency, then back-to-back node and newline
    send(15'h61D4, 1'b0, 1'b0);
    chk("first_char_latency", {8'd0, bus.o_char}, 16'h0079);
    chk("first_vld_latency", {15'd0, bus.o_vld}, 16'd1);
    send(15'h3A93, 1'b0, 1'b0);
    send(15'h0000, 1'b1, 1'b0);
    drain();
    chk_log("you: out\n");
    if (lc.size() >= 9) chk("no_bubble", lc[8] - lc[0], 16'd8);

    // Downstream stall while 'o' is presented
    do_reset();
    send(15'h61D4, 1'b0, 1'b0);
    cyc();
    chk("stall_pre", {8'd0, bus.o_char}, 16'h006F);
    bus.i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_hold_char", {8'd0, bus.o_char}, 16'h006F);
      chk("stall_hold_vld", {15'd0, bus.o_vld}, 16'd1);
      chk("stall_hold_ostall", {15'd0, bus.o_stall}, 16'd1);
    end
    bus.i_stall = 1'b0;
    cyc();
    chk("stall_resume", {8'd0, bus.o_char}, 16'h0075);
    drain();
    chk_log("you:");

    // Out-of-range letter code
    do_reset();
    send(15'h7C00, 1'b0, 1'b0);
    drain();
    chk_log("?aa:");
    chk("bad_err", {15'd0, bus.o_err}, 16'd1);
    send(15'h0000, 1'b1, 1'b0);
    drain();
    chk("bad_err_sticky", {15'd0, bus.o_err}, 16'd1);

    // Reset in the middle of a token
    send(15'h61D4, 1'b0, 1'b0);
    cyc();
    cyc();
    do_reset();
    send(15'h3A93, 1'b0, 1'b0);
    drain();
    chk_log("out:");
    chk("mid_rst_err", {15'd0, bus.o_err}, 16'd0);

    // Loopback: parse emitted text back into tokens
    do_reset();
    send(15'h61D4, 1'b0, 1'b0);
    send(15'h0421, 1'b0, 1'b1 & ($urandom_range(0, 1) == 1));
    bus.i_stall = 1'b0;
    send(15'h0842, 1'b0, 1'b0);
    send(15'h0000, 1'b1, 1'b0);
    drain();
    acc = 15'd0; nlet = 0;
    foreach (lq[i]) begin
      if (lq[i] == 8'h0A) toks.push_back(16'h8000);
      else if (lq[i] >= 8'h61 && lq[i] <= 8'h7A) begin
        lv   = 5'(lq[i] - 8'h61);
        acc  = {acc[9:0], lv};
        nlet = nlet + 1;
        if (nlet == 3) begin
          toks.push_back({1'b0, acc});
          nlet = 0;
        end
      end
    end
    want[0] = 16'h61D4; want[1] = 16'h0421; want[2] = 16'h0842; want[3] = 16'h8000;
    chk("loop_count", toks.size(), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < toks.size()) chk("loop_token", toks[i], want[i]);
    end

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bus.i_node_vld = ($urandom_range(0, 3) != 0);
      bus.i_newline  = ($urandom_range(0, 5) == 0);
      for (int j = 0; j < 3; j++) begin
        lv = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31))
                                         : 5'($urandom_range(0, 25));
        bus.i_node_str = {bus.i_node_str[9:0], lv};
      end
      bus.i_stall = ($urandom_range(0, 2) == 0);
      cyc();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
